// File: rtl/fp24_add_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fp24_add_arbiter
//
// Purpose
//   Shares a single fp24 adder between NUM_REQ requesters. A round-robin
//   arbiter picks one requester per cycle, its operands are captured in
//   stage S1, the adder works from the S1 registers, and the result is held
//   in stage S2, which drives the result port. Backpressure on the result
//   port stalls S2 and then S1, so no accepted operation is lost or repeated.
//
//   fp24 layout: sign[23], exponent[22:16] (bias 63), mantissa[15:0] with an
//   implied leading one. An exponent field of zero means the value is zero.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester operation valid              [NUM_REQ]
//   req_ready  per-requester accept, one-hot or zero      [NUM_REQ]
//   req_a      per-requester operand a, 24 bits each      [NUM_REQ*24]
//   req_b      per-requester operand b, 24 bits each      [NUM_REQ*24]
//   req_sub    per-requester op select, 1 = a-b, 0 = a+b  [NUM_REQ]
//   res_valid  result valid
//   res_ready  result consumer accept
//   res_id     index of the requester owning the result
//   res_sum    fp24 result
//   op_count   completed result transfers, wraps at 16 bits
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fp24_add
//
// Purpose
//   Combinational fp24 adder/subtractor. Operands are swapped so the larger
//   magnitude is always on the "big" side, the smaller one is aligned to it,
//   the mantissas are added or subtracted, and the result is renormalised.
//   Three guard bits below the mantissa keep one-bit cancellation exact;
//   the final result is truncated. Exponent overflow saturates to the
//   largest exponent with a zero mantissa, underflow flushes to zero.
//
// Ports
//   a, b  fp24 operands
//   sub   1 = a-b, 0 = a+b
//   sum   fp24 result
// ---------------------------------------------------------------------------
module fp24_add (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        sub,
  output logic [23:0] sum
);

  logic        b_sign;
  logic        swap;
  logic        big_sign;
  logic        small_sign;
  logic        eff_sub;
  logic [6:0]  big_exp;
  logic [6:0]  small_exp;
  logic [6:0]  exp_diff;
  logic [6:0]  norm_exp;
  logic [19:0] big_man;
  logic [19:0] small_man;
  logic [19:0] small_aligned;
  logic [20:0] raw;
  logic [4:0]  lead_zeros;
  logic [7:0]  inc_exp;
  logic [15:0] norm_man;

  // Whole datapath in one block: order operands, align, add, renormalise.
  // Magnitude ordering compares {exp, mant} as one unsigned number, which
  // is valid because the exponent sits above the mantissa.
  always_comb begin
    b_sign = b[23] ^ sub;
    swap   = (b[22:0] > a[22:0]);

    if (swap) begin
      big_sign   = b_sign;
      big_exp    = b[22:16];
      big_man    = (b[22:16] == 7'd0) ? 20'd0 : {1'b1, b[15:0], 3'b000};
      small_sign = a[23];
      small_exp  = a[22:16];
      small_man  = (a[22:16] == 7'd0) ? 20'd0 : {1'b1, a[15:0], 3'b000};
    end else begin
      big_sign   = a[23];
      big_exp    = a[22:16];
      big_man    = (a[22:16] == 7'd0) ? 20'd0 : {1'b1, a[15:0], 3'b000};
      small_sign = b_sign;
      small_exp  = b[22:16];
      small_man  = (b[22:16] == 7'd0) ? 20'd0 : {1'b1, b[15:0], 3'b000};
    end

    exp_diff      = big_exp - small_exp;
    small_aligned = small_man >> exp_diff;
    eff_sub       = big_sign ^ small_sign;

    if (eff_sub) begin
      raw = {1'b0, big_man} - {1'b0, small_aligned};
    end else begin
      raw = {1'b0, big_man} + {1'b0, small_aligned};
    end

    // Ascending scan: the last hit is the highest set bit.
    lead_zeros = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (raw[i]) begin
        lead_zeros = 5'(19 - i);
      end
    end

    norm_man = 16'((raw[19:0] << lead_zeros) >> 3);
    norm_exp = big_exp - {2'b00, lead_zeros};
    inc_exp  = {1'b0, big_exp} + 8'd1;

    sum = 24'd0;
    if (raw == 21'd0) begin
      sum = 24'd0;
    end else if (raw[20]) begin
      // Carry out of the mantissa: shift right one and bump the exponent.
      if (inc_exp >= 8'd127) begin
        sum = {big_sign, 7'h7F, 16'h0000};
      end else begin
        sum = {big_sign, inc_exp[6:0], raw[19:4]};
      end
    end else if ({2'b00, lead_zeros} >= big_exp) begin
      sum = 24'd0;
    end else begin
      sum = {big_sign, norm_exp, norm_man};
    end
  end

endmodule

module fp24_add_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*24-1:0]      req_a,
  input  logic [NUM_REQ*24-1:0]      req_b,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [23:0]                res_sum,
  output logic [15:0]                op_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = IDW + 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] gnt_idx;
  logic [CW-1:0]  cand;
  logic [CW-1:0]  nxt;
  logic           found;
  logic           grant;

  logic           s1_valid;
  logic [23:0]    s1_a;
  logic [23:0]    s1_b;
  logic           s1_sub;
  logic [IDW-1:0] s1_id;

  logic           s2_valid;
  logic           s2_load;
  logic           s1_accept;
  logic [23:0]    add_sum;

  // S2 takes a new result whenever S1 holds one and S2 is empty or being
  // drained this cycle; S1 can take a grant when empty or emptying into S2.
  assign s2_load   = s1_valid && (!s2_valid || res_ready);
  assign s1_accept = !s1_valid || s2_load;
  assign res_valid = s2_valid;

  // Round-robin search starting at ptr. The candidate index is kept one bit
  // wider than needed so the wrap can be done by a compare and subtract,
  // which also works when NUM_REQ is not a power of two.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // A grant only happens when S1 has room; reset masks it so nothing is
  // offered while the pipeline is being cleared.
  assign grant = found && s1_accept && !rst;

  // Ready is the one-hot decode of the winner, and all zero without a grant.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves to the requester after the winner, wrapping to zero.
  always_comb begin
    nxt = {1'b0, gnt_idx} + CW'(1);
    if (nxt >= CW'(NUM_REQ)) begin
      nxt = '0;
    end
    ptr_next = nxt[IDW-1:0];
  end

  // Arbitration pointer register; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= ptr_next;
    end
  end

  // Stage S1: captures the winner's operands. When S1 is free to accept but
  // nobody is granted, it empties so the same operation is not sent twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 24'd0;
      s1_b     <= 24'd0;
      s1_sub   <= 1'b0;
      s1_id    <= '0;
    end else if (s1_accept) begin
      s1_valid <= grant;
      if (grant) begin
        s1_a   <= req_a[gnt_idx*24 +: 24];
        s1_b   <= req_b[gnt_idx*24 +: 24];
        s1_sub <= req_sub[gnt_idx];
        s1_id  <= gnt_idx;
      end
    end
  end

  // The single shared adder works straight from the S1 registers.
  fp24_add u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sub (s1_sub),
    .sum (add_sum)
  );

  // Stage S2: result register driving the result port. It holds everything
  // while the consumer stalls, so the outputs are stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_sum  <= 24'd0;
      res_id   <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      res_sum  <= add_sum;
      res_id   <= s1_id;
    end else if (res_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Completed-transfer counter; natural 16-bit wrap from 0xFFFF to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (s2_valid && res_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp24_add_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fp24_add_arbiter
//
// Purpose
//   Self-checking bench for fp24_add_arbiter with four requesters. Handshakes
//   seen on the request side push the expected result into a queue; results
//   leaving the block pop it and are compared. A fixed table of hand-worked
//   vectors exercises the adder and the latency, and short sequences cover
//   fairness, backpressure, reset in flight and counter wrap.
// ---------------------------------------------------------------------------
module tb_fp24_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_VEC = 10;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*24-1:0] req_a;
  logic [NUM_REQ*24-1:0] req_b;
  logic [NUM_REQ-1:0]   req_sub;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_id;
  logic [23:0]          res_sum;
  logic [15:0]          op_count;

  typedef struct {
    logic [1:0]  id;
    logic [23:0] sum;
  } sb_entry_t;

  typedef struct {
    int          id;
    logic [23:0] a;
    logic [23:0] b;
    logic        sub;
    logic [23:0] exp_sum;
  } vec_t;

  sb_entry_t   sb_q[$];
  sb_entry_t   sb_e;
  int          grant_log[$];
  int          res_log[$];
  logic [23:0] exp_for [NUM_REQ];
  vec_t        vecs [NUM_VEC];

  int          vec_count;
  int          miss_count;
  int          stale_seen;
  logic        got;
  logic [23:0] held_sum;
  logic [1:0]  held_id;

  fp24_add_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .op_count  (op_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never settles.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Encodes a small signed integer as fp24; the reference for the traffic
  // phases, where expected sums are plain integer arithmetic.
  function automatic logic [23:0] to_fp(input int n);
    int   m;
    int   p;
    logic s;
    if (n == 0) return 24'd0;
    s = (n < 0);
    m = s ? -n : n;
    p = 0;
    for (int k = 0; k < 17; k++) begin
      if ((m >> k) != 0) p = k;
    end
    return {s, 7'(63 + p), 16'((m << (16 - p)) & 32'h0000FFFF)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Puts one requester's operands on the bus together with the sum it
  // should produce; valid is handled by the caller.
  task automatic applyStimulus(input int id, input logic [23:0] a, input logic [23:0] b,
                               input logic sub, input logic [23:0] exp_sum);
    req_a[id*24 +: 24] = a;
    req_b[id*24 +: 24] = b;
    req_sub[id]        = sub;
    exp_for[id]        = exp_sum;
  endtask

  // Scoreboard monitor, sampled on the falling edge: records the handshakes
  // that the next rising edge will take, and checks results being consumed.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      checkOutput("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back('{id: 2'(i), sum: exp_for[i]});
          grant_log.push_back(i);
        end
      end
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          vec_count++;
          miss_count++;
          $display("[TB] FAIL unexpected_result: got id=%0d sum=0x%06h, required no result", res_id, res_sum);
        end else begin
          sb_e = sb_q.pop_front();
          checkOutput("res_sum", 32'(res_sum), 32'(sb_e.sum));
          checkOutput("res_id", 32'(res_id), 32'(sb_e.id));
        end
        res_log.push_back(int'(res_id));
      end
    end
  end

  initial begin
    // id, a, b, sub, expected sum (hand-worked fp24 constants)
    vecs[0] = '{2, 24'h3F0000, 24'h3F0000, 1'b0, 24'h400000}; // 1+1=2
    vecs[1] = '{0, 24'h3F0000, 24'h000000, 1'b0, 24'h3F0000}; // 1+0=1
    vecs[2] = '{1, 24'h408000, 24'h3F0000, 1'b0, 24'h410000}; // 3+1=4
    vecs[3] = '{3, 24'h408000, 24'h3F0000, 1'b1, 24'h400000}; // 3-1=2
    vecs[4] = '{1, 24'h3F0000, 24'h408000, 1'b1, 24'hC00000}; // 1-3=-2
    vecs[5] = '{0, 24'h414000, 24'h408000, 1'b0, 24'h420000}; // 5+3=8
    vecs[6] = '{2, 24'h41C000, 24'h3F0000, 1'b0, 24'h420000}; // 7+1=8
    vecs[7] = '{3, 24'h400000, 24'h400000, 1'b1, 24'h000000}; // 2-2=0
    vecs[8] = '{1, 24'h459000, 24'h43C000, 1'b0, 24'h460000}; // 100+28=128
    vecs[9] = '{0, 24'h418000, 24'h414000, 1'b1, 24'h3F0000}; // 6-5=1

    vec_count  = 0;
    miss_count = 0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    res_ready  = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) exp_for[i] = 24'd0;

    // Reset state, checked before any clock edge with requests pending.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req_valid = '1;
    #1;
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_sum", 32'(res_sum), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors, one at a time, with latency and counter checks.
    for (int v = 0; v < NUM_VEC; v++) begin
      applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].exp_sum);
      req_valid = 4'(1 << vecs[v].id);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = req_ready[vecs[v].id];
      end
      if (!got) begin
        vec_count++;
        miss_count++;
        $display("[TB] FAIL grant_timeout: requester %0d not granted, required grant within 10 cycles", vecs[v].id);
      end
      @(posedge clk); #1;
      req_valid = '0;
      checkOutput("latency_edge1", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("latency_edge2", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
      checkOutput("op_count_table", 32'(op_count), 32'(v + 1));
    end

    // Fairness: fresh reset, all four requesters continuously valid.
    for (int i = 0; i < NUM_REQ; i++) begin
      applyStimulus(i, to_fp(i + 1), to_fp(2), 1'(i % 2),
                    (i % 2 == 1) ? to_fp(i + 1 - 2) : to_fp(i + 1 + 2));
    end
    rst = 1'b1;
    sb_q.delete();
    req_valid = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
    res_log.delete();
    checkOutput("op_count_after_reset", 32'(op_count), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("fair_grant_count", 32'(grant_log.size()), 32'd8);
    checkOutput("fair_result_count", 32'(res_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      checkOutput("fair_grant_order", 32'(grant_log[k]), 32'(k % NUM_REQ));
    end
    for (int k = 0; k < 8 && k < res_log.size(); k++) begin
      checkOutput("fair_result_order", 32'(res_log[k]), 32'(k % NUM_REQ));
    end
    checkOutput("op_count_fair", 32'(op_count), 32'd8);

    // Backpressure: consumer stalls for five cycles with everybody valid.
    grant_log.delete();
    res_log.delete();
    req_valid = '1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
    checkOutput("bp_ready_full", 32'(req_ready), 32'd0);
    held_sum = res_sum;
    held_id  = res_id;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("bp_ready_stall", 32'(req_ready), 32'd0);
      checkOutput("bp_hold_sum", 32'(res_sum), 32'(held_sum));
      checkOutput("bp_hold_id", 32'(res_id), 32'(held_id));
      checkOutput("bp_hold_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp_grant_count", 32'(grant_log.size()), 32'd6);
    checkOutput("bp_result_count", 32'(res_log.size()), 32'd6);
    checkOutput("bp_queue_empty", 32'(sb_q.size()), 32'd0);

    // Reset with both stages full; asserted away from any clock edge.
    req_valid = '1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midrst_full_valid", 32'(res_valid), 32'd1);
    checkOutput("midrst_full_ready", 32'(req_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_op_count", 32'(op_count), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    rst = 1'b0;
    stale_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (res_valid) stale_seen++;
    end
    checkOutput("midrst_stale", 32'(stale_seen), 32'd0);

    // Counter wrap: full-rate traffic until 0xFFFF, then one more transfer.
    req_valid = '1;
    got = 1'b0;
    for (int c = 0; c < 70000 && !got; c++) begin
      @(posedge clk); #1;
      got = (op_count == 16'hFFFF);
    end
    res_ready = 1'b0;
    req_valid = '0;
    if (!got) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL wrap_timeout: op_count=0x%04h, required 0xFFFF within 70000 cycles", op_count);
    end
    @(posedge clk); #1;
    checkOutput("wrap_hold", 32'(op_count), 32'h0000FFFF);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("wrap_zero", 32'(op_count), 32'd0);
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wrap_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fp24_add_arbiter.md
FP24_ADD_ARBITER -- requirements
Module: fp24_add_arbiter

Interface
REQ-001 The block SHALL have one parameter: NUM_REQ, default 4, meaning the number of requesters sharing the adder (2..8).
REQ-002 Ports SHALL be:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  input  NUM_REQ x 24  per-requester operand a (fp24)
- req_b  input  NUM_REQ x 24  per-requester operand b (fp24)
- req_sub  input  NUM_REQ  per-requester 1 = a-b, 0 = a+b
- res_valid  output  1  result valid
- res_ready  input  1  result consumer accept
- res_id  output  $clog2(NUM_REQ)  index of requester owning result
- res_sum  output  24  fp24 result
- op_count  output  16  number of completed result transfers

Function
REQ-003 The block SHALL instantiate exactly one fp24_add, fed from stage S1 registers; fp24 format is sign[23], exp[22:16], mant[15:0].
REQ-004 Pipeline SHALL be two register stages:
- S1: operands, sub flag, id, s1_valid.
- S2: sum, id, s2_valid, driving res_*.
REQ-005 Latency SHALL be 2 cycles from the accepting edge (req_valid&req_ready) to res_valid high, absent backpressure.
REQ-006 S2 SHALL load when s1_valid and (!s2_valid or res_ready); otherwise it holds all values.
REQ-007 S1 SHALL accept a new grant when !s1_valid or S1 moves to S2 in the same cycle.
REQ-008 s1_valid SHALL clear when S1 moves to S2 without a new grant.
REQ-009 s2_valid SHALL clear when res_ready is high and S2 does not load.
REQ-010 Arbitration SHALL be round-robin via pointer ptr: search starts at ptr, wraps at NUM_REQ-1 to 0, and selects the first asserted req_valid.
REQ-011 req_ready SHALL be combinational: one-hot on the selected requester when S1 can accept (REQ-007), else all zero.
REQ-012 req_ready SHALL never assert for a requester whose req_valid is low.
REQ-013 On a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; without a grant, ptr SHALL hold.
REQ-014 With every requester continuously valid and no backpressure, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0 with one grant per cycle.
REQ-015 res_sum, res_id and res_valid SHALL remain stable while res_valid&&!res_ready.
REQ-016 op_count SHALL increment by 1 on each cycle with res_valid&&res_ready, and SHALL wrap from 0xFFFF to 0x0000.
REQ-017 Full throughput SHALL be one operation per cycle.
REQ-018 Backpressure SHALL stall both stages with no loss or duplication of any accepted operation.

Reset
REQ-019 While rst is high, asynchronously and independent of clk:
- s1_valid=0, s2_valid=0, so res_valid=0.
- res_sum=0, res_id=0, ptr=0, op_count=0.
- req_ready=0.
REQ-020 Operations accepted before reset SHALL be discarded, including those in flight when reset asserts mid-operation.
REQ-021 The first grant after rst deasserts SHALL be the lowest-indexed valid requester.

Verification
REQ-022 Single op: requester 2 sends a=0x3F0000, b=0x3F0000, sub=0 with res_ready=1 -> res_valid=1 exactly 2 cycles later with res_sum=0x400000 and res_id=2; op_count becomes 1.
REQ-023 Zero operand: requester 0 sends a=0x3F0000, b=0x000000 -> res_sum=0x3F0000, res_id=0.
REQ-024 Fairness: all 4 requesters valid for 8 cycles with res_ready=1 -> grant order 0,1,2,3,0,1,2,3, and each res_id appears twice in that order.
REQ-025 Backpressure: res_ready=0 for 5 cycles with all requesters valid ->
- After both stages fill, req_ready=0.
- res_sum and res_id stay constant.
- When res_ready is released, results drain in order with no loss.
REQ-026 Reset mid-flight: assert rst while s1_valid=1 and s2_valid=1 -> res_valid=0 immediately (asynchronous) and op_count=0; after release, no stale result appears.
REQ-027 Wrap: preload traffic until op_count=0xFFFF, then complete one transfer -> op_count=0x0000.
